// File: rtl/anc_pkg.sv
// Shared types and constants for the anti-noise mix stage.
package anc_pkg;

    typedef logic signed [15:0] sample_t;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        UP   = 2'd1,
        ON   = 2'd2,
        DOWN = 2'd3
    } ramp_state_t;

    localparam sample_t     SAMPLE_MAX = 16'sh7FFF;
    localparam sample_t     SAMPLE_MIN = 16'sh8000;
    localparam logic [15:0] GAIN_UNITY = 16'h8000;

    // Gains above unity are meaningless in Q1.15 and are pinned to unity.
    function automatic logic [15:0] clamp_gain(input logic [15:0] gain);
        return (gain > GAIN_UNITY) ? GAIN_UNITY : gain;
    endfunction

endpackage

// File: rtl/anc_mix_stage_if.sv
// Sample-side bus of the mix stage: strobed inputs and the mixed output.
interface anc_mix_stage_if;
    import anc_pkg::*;

    logic        audio_valid_in;
    sample_t     audio_in;
    sample_t     anti_in;
    logic        enable_in;
    logic [15:0] gain_in;
    sample_t     mix_out;
    logic        mix_valid_out;
    logic        sat_out;
    logic [1:0]  ramp_state_out;
    logic        overrun_out;

    modport master (
        output audio_valid_in, audio_in, anti_in, enable_in, gain_in,
        input  mix_out, mix_valid_out, sat_out, ramp_state_out, overrun_out
    );

    modport slave (
        input  audio_valid_in, audio_in, anti_in, enable_in, gain_in,
        output mix_out, mix_valid_out, sat_out, ramp_state_out, overrun_out
    );

endinterface

// File: rtl/sat_add16.sv
// Signed add of a 16-bit sample and an 18-bit scaled term, saturated to 16 bits.
module sat_add16
    import anc_pkg::*;
(
    input  sample_t            a,
    input  logic signed [17:0] b,
    output sample_t            sum,
    output logic               ovf
);

    logic signed [18:0] wide_s;

    // Full-precision sum, then clamp to the 16-bit signed range
    always_comb begin
        wide_s = $signed({{3{a[15]}}, a}) + $signed({b[17], b});
        if (wide_s > 19'sd32767) begin
            sum = SAMPLE_MAX;
            ovf = 1'b1;
        end else if (wide_s < -19'sd32768) begin
            sum = SAMPLE_MIN;
            ovf = 1'b1;
        end else begin
            sum = wide_s[15:0];
            ovf = 1'b0;
        end
    end

endmodule

// File: rtl/anc_mix_stage.sv
// Mixes the delayed anti-noise into the direct path with gain, fade ramp and
// saturation; one mixed sample per accepted strobe, ANTI_LAT+2 cycles later.
module anc_mix_stage
    import anc_pkg::*;
#(
    parameter int ANTI_LAT   = 3,
    parameter int RAMP_SHIFT = 8
) (
    input  logic            clk_in,
    input  logic            rst_in,
    anc_mix_stage_if.slave  bus
);

    localparam int CNT_W  = $clog2(ANTI_LAT + 3);
    localparam int LVL_W  = RAMP_SHIFT + 1;
    localparam int PROD_W = 17 + RAMP_SHIFT;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ANTI_LAT + 2);
    localparam logic [CNT_W-1:0] CNT_ANTI = CNT_W'(3);
    localparam logic [CNT_W-1:0] CNT_PROD = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_OUT  = CNT_W'(1);
    localparam logic [LVL_W-1:0] LVL_MAX  = {1'b1, {RAMP_SHIFT{1'b0}}};

    logic [CNT_W-1:0]   cnt_r;
    ramp_state_t        state_r;
    logic [LVL_W-1:0]   level_r;
    sample_t            audio_r;
    sample_t            anti_r;
    logic [16:0]        eff_gain_r;
    logic signed [17:0] prod_r;
    sample_t            mix_r;
    logic               mix_valid_r;
    logic               sat_r;
    logic               overrun_r;

    logic               busy_s;
    logic               accept_s;
    ramp_state_t        state_nxt_s;
    logic [LVL_W-1:0]   level_nxt_s;
    logic [PROD_W-1:0]  gain_prod_s;
    logic [16:0]        eff_gain_s;
    logic signed [33:0] prod_full_s;
    logic signed [17:0] prod_s;
    sample_t            sum_s;
    logic               ovf_s;

    // The down-counter doubles as the busy flag for the whole capture window
    assign busy_s   = (cnt_r != '0);
    assign accept_s = bus.audio_valid_in && !busy_s;

    // Ramp transitions; the level used by the current sample is the pre-update value
    always_comb begin
        state_nxt_s = state_r;
        level_nxt_s = level_r;
        case (state_r)
            OFF: begin
                if (bus.enable_in) begin
                    level_nxt_s = level_r + 1'b1;
                    state_nxt_s = (level_nxt_s == LVL_MAX) ? ON : UP;
                end else begin
                    level_nxt_s = '0;
                end
            end
            UP: begin
                if (!bus.enable_in) begin
                    state_nxt_s = DOWN;
                end else if (level_r < LVL_MAX) begin
                    level_nxt_s = level_r + 1'b1;
                    state_nxt_s = (level_nxt_s == LVL_MAX) ? ON : UP;
                end else begin
                    state_nxt_s = ON;
                end
            end
            ON: begin
                if (!bus.enable_in) begin
                    state_nxt_s = DOWN;
                end else begin
                    level_nxt_s = LVL_MAX;
                end
            end
            DOWN: begin
                if (bus.enable_in) begin
                    state_nxt_s = UP;
                end else if (level_r != '0) begin
                    level_nxt_s = level_r - 1'b1;
                    state_nxt_s = (level_nxt_s == '0) ? OFF : DOWN;
                end else begin
                    state_nxt_s = OFF;
                end
            end
            default: begin
                state_nxt_s = OFF;
                level_nxt_s = '0;
            end
        endcase
    end

    // Effective gain at accept time and the floor-scaled anti-noise term
    always_comb begin
        gain_prod_s = PROD_W'(clamp_gain(bus.gain_in)) * PROD_W'(level_r);
        eff_gain_s  = 17'(gain_prod_s >> RAMP_SHIFT);
        prod_full_s = 34'(anti_r) * $signed(34'(eff_gain_r));
        prod_s      = 18'(prod_full_s >>> 15);
    end

    sat_add16 u_sat_add (
        .a   (audio_r),
        .b   (prod_r),
        .sum (sum_s),
        .ovf (ovf_s)
    );

    // Capture, ramp FSM, product and output stages plus sticky overrun
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt_r       <= '0;
            state_r     <= OFF;
            level_r     <= '0;
            audio_r     <= '0;
            anti_r      <= '0;
            eff_gain_r  <= '0;
            prod_r      <= '0;
            mix_r       <= '0;
            mix_valid_r <= 1'b0;
            sat_r       <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                cnt_r      <= CNT_LOAD;
                audio_r    <= bus.audio_in;
                eff_gain_r <= eff_gain_s;
                state_r    <= state_nxt_s;
                level_r    <= level_nxt_s;
            end else if (busy_s) begin
                cnt_r <= cnt_r - 1'b1;
            end
            if (bus.audio_valid_in && busy_s) begin
                overrun_r <= 1'b1;
            end
            if (cnt_r == CNT_ANTI) begin
                anti_r <= bus.anti_in;
            end
            if (cnt_r == CNT_PROD) begin
                prod_r <= prod_s;
            end
            if (cnt_r == CNT_OUT) begin
                mix_r <= sum_s;
            end
            mix_valid_r <= (cnt_r == CNT_OUT);
            sat_r       <= (cnt_r == CNT_OUT) && ovf_s;
        end
    end

    assign bus.mix_out        = mix_r;
    assign bus.mix_valid_out  = mix_valid_r;
    assign bus.sat_out        = sat_r;
    assign bus.ramp_state_out = state_r;
    assign bus.overrun_out    = overrun_r;

endmodule

// File: tb/tb_anc_mix_stage.sv
// Self-checking bench for anc_mix_stage: directed scenarios plus randomized
// samples against an arithmetic reference model of the ramp and mix rules.
module tb_anc_mix_stage;
    import anc_pkg::*;

    localparam int ANTI_LAT   = 3;
    localparam int RAMP_SHIFT = 2;
    localparam int LMAX       = 1 << RAMP_SHIFT;
    localparam int VPOS       = ANTI_LAT + 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    anc_mix_stage_if bus();

    anc_mix_stage #(.ANTI_LAT(ANTI_LAT), .RAMP_SHIFT(RAMP_SHIFT)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state: 0=OFF 1=UP 2=ON 3=DOWN
    int m_state = 0;
    int m_level = 0;
    bit m_ovr   = 1'b0;

    typedef struct {
        int          vpos;
        logic [15:0] mix;
        logic        sat;
        logic [1:0]  st;
        logic        ovr;
    } obs_t;

    typedef struct {
        logic [15:0] mix;
        logic        sat;
        logic [1:0]  st;
    } exp_t;

    task automatic model_reset();
        m_state = 0;
        m_level = 0;
        m_ovr   = 1'b0;
    endtask

    task automatic model_sample(input logic [15:0] audio, input logic [15:0] anti,
                                input logic [15:0] gain, input logic en, output exp_t e);
        longint g, eff, p, s;
        g   = (gain > 16'h8000) ? 64'sd32768 : longint'(gain);
        eff = (g * m_level) / LMAX;
        p   = longint'($signed(anti)) * eff;
        p   = (p >= 0) ? p / 32768 : -((-p + 32767) / 32768);
        s   = longint'($signed(audio)) + p;
        e.sat = (s > 32767) || (s < -32768);
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        e.mix = 16'(s);
        case (m_state)
            0: if (en) begin m_level = 1; m_state = (m_level == LMAX) ? 2 : 1; end
            1: if (!en) m_state = 3;
               else begin m_level = m_level + 1; if (m_level == LMAX) m_state = 2; end
            2: if (!en) m_state = 3;
            default: if (en) m_state = 1;
               else begin m_level = m_level - 1; if (m_level == 0) m_state = 0; end
        endcase
        e.st = 2'(m_state);
    endtask

    // Strobe one sample at the current negedge; anti_in is only correct
    // ANTI_LAT cycles later, every other input is noise between strobes.
    task automatic do_sample(input logic [15:0] audio, input logic [15:0] anti,
                             input logic [15:0] gain, input logic en,
                             input int inject, output obs_t o);
        o.vpos = -1; o.mix = '0; o.sat = 1'b0; o.st = '0;
        bus.audio_valid_in = 1'b1;
        bus.audio_in  = audio;
        bus.gain_in   = gain;
        bus.enable_in = en;
        bus.anti_in   = 16'($urandom);
        for (int j = 1; j <= VPOS; j++) begin
            @(negedge clk);
            if (j == 1) o.st = bus.ramp_state_out;
            if (bus.mix_valid_out) begin
                o.vpos = (o.vpos == -1) ? j : -2;
                o.mix  = bus.mix_out;
                o.sat  = bus.sat_out;
            end
            if (j < VPOS) begin
                bus.audio_valid_in = (j == inject);
                bus.audio_in  = 16'($urandom);
                bus.gain_in   = 16'($urandom);
                bus.enable_in = 1'($urandom);
                bus.anti_in   = (j == ANTI_LAT) ? anti : 16'($urandom);
            end
        end
        o.ovr = bus.overrun_out;
    endtask

    task automatic test_reset();
        int seen;
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.audio_valid_in = 1'($urandom);
            bus.audio_in  = 16'($urandom);
            bus.anti_in   = 16'($urandom);
            bus.gain_in   = 16'($urandom);
            bus.enable_in = 1'($urandom);
            n_tests++;
            if ({bus.mix_out, bus.mix_valid_out, bus.sat_out, bus.ramp_state_out, bus.overrun_out} !== 21'd0) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: got %h want 0", i,
                         {bus.mix_out, bus.mix_valid_out, bus.sat_out, bus.ramp_state_out, bus.overrun_out});
            end
        end
        @(negedge clk);
        bus.audio_valid_in = 1'b0;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        // accept a sample, then reset mid-flight: no valid must follow
        bus.audio_valid_in = 1'b1; bus.enable_in = 1'b1; bus.audio_in = 16'h1234;
        @(negedge clk);
        bus.audio_valid_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int j = 0; j < VPOS + 2; j++) begin
            @(negedge clk);
            if (bus.mix_valid_out) seen++;
        end
        n_tests++;
        if (seen != 0) begin n_fail++; $display("FAIL reset_inflight_valid: got %0d pulses want 0", seen); end
        n_tests++;
        if (bus.ramp_state_out !== 2'd0) begin n_fail++; $display("FAIL reset_inflight_state: got %0d want 0", bus.ramp_state_out); end
    endtask

    task automatic test_bypass();
        obs_t o; exp_t e;
        model_sample(16'h1000, 16'h7000, 16'h8000, 1'b0, e);
        do_sample(16'h1000, 16'h7000, 16'h8000, 1'b0, 0, o);
        n_tests++;
        if (o.vpos !== VPOS) begin n_fail++; $display("FAIL bypass_valid_pos: got %0d want %0d", o.vpos, VPOS); end
        n_tests++;
        if (o.mix !== 16'h1000) begin n_fail++; $display("FAIL bypass_mix: got %h want 1000", o.mix); end
        n_tests++;
        if (o.sat !== 1'b0 || o.st !== 2'd0) begin n_fail++; $display("FAIL bypass_sat_state: got %b/%0d want 0/0", o.sat, o.st); end
    endtask

    task automatic test_fade_in();
        logic [15:0] tbl [6];
        obs_t o; exp_t e;
        tbl = '{16'h1000, 16'h0C00, 16'h0800, 16'h0400, 16'h0000, 16'h0000};
        for (int i = 0; i < 6; i++) begin
            model_sample(16'h1000, 16'hF000, 16'h8000, 1'b1, e);
            do_sample(16'h1000, 16'hF000, 16'h8000, 1'b1, 0, o);
            n_tests++;
            if (o.vpos !== VPOS || o.mix !== tbl[i]) begin
                n_fail++; $display("FAIL fade_in_mix[%0d]: got %h@%0d want %h@%0d", i, o.mix, o.vpos, tbl[i], VPOS);
            end
            n_tests++;
            if (o.st !== e.st) begin n_fail++; $display("FAIL fade_in_state[%0d]: got %0d want %0d", i, o.st, e.st); end
        end
    endtask

    task automatic test_reversal();
        logic [15:0] tail [3];
        logic        ens  [6];
        obs_t o; exp_t e;
        tail = '{16'h0800, 16'h0C00, 16'h1000};
        ens  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int g = 0; g < 12 && m_state != 0; g++) begin
            model_sample(16'h1000, 16'hF000, 16'h8000, 1'b0, e);
            do_sample(16'h1000, 16'hF000, 16'h8000, 1'b0, 0, o);
            n_tests++;
            if (o.mix !== e.mix || o.st !== e.st || o.vpos !== VPOS) begin
                n_fail++; $display("FAIL fade_out[%0d]: got %h/%0d want %h/%0d", g, o.mix, o.st, e.mix, e.st);
            end
        end
        for (int i = 0; i < 6; i++) begin
            model_sample(16'h1000, 16'hF000, 16'h8000, ens[i], e);
            do_sample(16'h1000, 16'hF000, 16'h8000, ens[i], 0, o);
            n_tests++;
            if (o.mix !== e.mix || o.st !== e.st || o.vpos !== VPOS) begin
                n_fail++; $display("FAIL reversal[%0d]: got %h/%0d want %h/%0d", i, o.mix, o.st, e.mix, e.st);
            end
            if (i >= 3) begin
                n_tests++;
                if (o.mix !== tail[i-3]) begin n_fail++; $display("FAIL reversal_tail[%0d]: got %h want %h", i, o.mix, tail[i-3]); end
            end
        end
        n_tests++;
        if (bus.ramp_state_out !== 2'd0) begin n_fail++; $display("FAIL reversal_end_state: got %0d want 0", bus.ramp_state_out); end
    endtask

    task automatic test_saturation();
        logic [15:0] aud [2];
        logic [15:0] ant [2];
        logic [15:0] res [2];
        obs_t o; exp_t e;
        aud = '{16'h7000, 16'h8000};
        ant = '{16'h7000, 16'h9000};
        res = '{16'h7FFF, 16'h8000};
        for (int g = 0; g < 12 && m_state != 2; g++) begin
            model_sample(16'h0000, 16'h0000, 16'h8000, 1'b1, e);
            do_sample(16'h0000, 16'h0000, 16'h8000, 1'b1, 0, o);
        end
        for (int i = 0; i < 2; i++) begin
            model_sample(aud[i], ant[i], 16'h8000, 1'b1, e);
            do_sample(aud[i], ant[i], 16'h8000, 1'b1, 0, o);
            n_tests++;
            if (o.mix !== res[i] || o.sat !== 1'b1 || o.vpos !== VPOS) begin
                n_fail++; $display("FAIL saturation[%0d]: got %h sat=%b want %h sat=1", i, o.mix, o.sat, res[i]);
            end
        end
    endtask

    task automatic test_random();
        logic        en;
        logic [15:0] a, n, g;
        obs_t o; exp_t e;
        en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 5) == 0) en = ~en;
            a = 16'($urandom);
            n = 16'($urandom);
            case ($urandom_range(0, 2))
                0: g = 16'h8000;
                1: g = 16'h8000 + 16'($urandom_range(1, 32767));
                default: g = 16'($urandom_range(0, 32767));
            endcase
            model_sample(a, n, g, en, e);
            do_sample(a, n, g, en, 0, o);
            n_tests++;
            if (o.vpos !== VPOS || o.mix !== e.mix || o.sat !== e.sat || o.st !== e.st || o.ovr !== m_ovr) begin
                n_fail++;
                $display("FAIL random[%0d]: got mix=%h sat=%b st=%0d pos=%0d ovr=%b want mix=%h sat=%b st=%0d pos=%0d ovr=%b",
                         i, o.mix, o.sat, o.st, o.vpos, o.ovr, e.mix, e.sat, e.st, VPOS, m_ovr);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_overrun();
        obs_t o; exp_t e;
        logic [15:0] a;
        for (int i = 0; i < 3; i++) begin
            a = 16'($urandom_range(0, 16'h3FFF));
            model_sample(a, 16'h0400, 16'h8000, 1'b1, e);
            do_sample(a, 16'h0400, 16'h8000, 1'b1, (i == 0) ? 2 : 0, o);
            if (i == 0) m_ovr = 1'b1;
            n_tests++;
            if (o.vpos !== VPOS || o.mix !== e.mix || o.st !== e.st) begin
                n_fail++; $display("FAIL overrun_sample[%0d]: got %h/%0d@%0d want %h/%0d@%0d", i, o.mix, o.st, o.vpos, e.mix, e.st, VPOS);
            end
            n_tests++;
            if (o.ovr !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky[%0d]: got %b want 1", i, o.ovr); end
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        n_tests++;
        if (bus.overrun_out !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b want 0", bus.overrun_out); end
    endtask

    initial begin
        bus.audio_valid_in = 1'b0;
        bus.audio_in  = '0;
        bus.anti_in   = '0;
        bus.gain_in   = '0;
        bus.enable_in = 1'b0;
        test_reset();
        @(negedge clk);
        test_bypass();
        test_fade_in();
        test_reversal();
        test_saturation();
        test_random();
        test_overrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
